mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Purpose : LC3-style memory controller; MAR/MDR registers plus an IDLE/ACCESS/DONE handshake FSM.
// Latency : access starts on the edge that samples mio_en; ready is high the cycle after mem_ack is sampled.
// Backpres: waits in ACCESS until mem_ack (or the optional timeout); ld_mar/ld_mdr/r_w are ignored meanwhile.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   bus_in, ld_mar, ld_mdr - processor bus and register load enables (honoured in IDLE only)
//   mio_en, r_w           - access request and direction (1 = write)
//   mar, mdr, ready       - address/data registers, one-cycle completion pulse
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack - memory-side handshake
//   timeout_err           - sticky timeout flag
// Build option: define MEM_CTRL_TIMEOUT_EN to abandon accesses that receive no mem_ack
// within TIMEOUT_CYCLES ACCESS cycles; otherwise timeout_err is tied low.
module mem_ctrl #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mio_en,
  input  logic              r_w,
  output logic [DATA_W-1:0] mar,
  output logic [DATA_W-1:0] mdr,
  output logic              ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mar_q, mar_nxt;
  logic [DATA_W-1:0] mdr_q, mdr_nxt;
  logic              we_q, we_nxt;
  logic              tmo_hit;

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Fires in the last permitted ACCESS cycle; mem_ack in that same cycle wins.
  assign tmo_hit = (state == ACCESS) && !mem_ack &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == ACCESS) cnt_q <= cnt_q + 1'b1;
      else                 cnt_q <= '0;
      if (tmo_hit)         err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mar_q <= '0;
      mdr_q <= '0;
      we_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      mar_q <= mar_nxt;
      mdr_q <= mdr_nxt;
      we_q  <= we_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mar_nxt   = mar_q;
    mdr_nxt   = mdr_q;
    we_nxt    = we_q;
    case (state)
      IDLE: begin
        if (ld_mar) mar_nxt = bus_in;
        // MDR is the write-data source once an access is requested, so a
        // concurrent ld_mdr must not disturb it.
        if (ld_mdr && !mio_en) mdr_nxt = bus_in;
        // A simultaneous ld_mar defers the start so the new address is used.
        if (mio_en && !ld_mar) begin
          we_nxt    = r_w;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          if (!we_q) mdr_nxt = mem_rdata;
          state_nxt = DONE;
        end else if (tmo_hit) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mar       = mar_q;
  assign mdr       = mdr_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_we    = we_q;
  assign mem_req   = (state == ACCESS);
  assign ready     = (state == DONE);

endmodule
